// File: rtl/rvh_l1d_ld_resp_queue_pkg.sv
// Shared encodings and entry layouts for the L1D load response path.
// Entry structs describe the default 4/4/12/2-bit tag, 64-bit data configuration.
package rvh_l1d_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef struct packed {
    logic [3:0]  rob_tag;
    logic [3:0]  prd;
    logic [11:0] lsu_tag;
    logic [63:0] data;
    logic        from_mlfb;
  } ld_resp_entry_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] pte;
  } ptw_resp_entry_t;

endpackage

// File: rtl/rvh_l1d_ld_resp_queue_if.sv
// Request / load writeback / PTW handshake bundle around the response queue.
// The queue itself connects through the slave modport.
interface rvh_l1d_ld_resp_queue_if #(
  parameter int WAY_NUM    = 4,
  parameter int LINE_BITS  = 512,
  parameter int XLEN       = 64,
  parameter int DEPTH      = 4,
  parameter int ROB_TAG_W  = 4,
  parameter int PREG_TAG_W = 4,
  parameter int LSU_TAG_W  = 12,
  parameter int PTW_ID_W   = 2
);
  localparam int OFF_W = $clog2(LINE_BITS/8);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_is_ptw_i;
  logic                  req_refill_i;
  logic [WAY_NUM-1:0]    req_way_hit_i;
  logic                  req_tlb_hit_i;
  logic [LINE_BITS-1:0]  req_line_i;
  logic [OFF_W-1:0]      req_offset_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic                  req_stb_byp_vld_i;
  logic [XLEN-1:0]       req_stb_byp_data_i;
  logic [ROB_TAG_W-1:0]  req_rob_tag_i;
  logic [PREG_TAG_W-1:0] req_prd_i;
  logic [LSU_TAG_W-1:0]  req_lsu_tag_i;

  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [ROB_TAG_W-1:0]  wb_rob_tag_o;
  logic [PREG_TAG_W-1:0] wb_prd_o;
  logic [LSU_TAG_W-1:0]  wb_lsu_tag_o;
  logic [XLEN-1:0]       wb_data_o;
  logic                  wb_from_mlfb_o;

  logic                  ptw_valid_o;
  logic                  ptw_ready_i;
  logic [PTW_ID_W-1:0]   ptw_id_o;
  logic [XLEN-1:0]       ptw_pte_o;

  logic [CNT_W-1:0]      ld_count_o;

  modport slave (
    input  req_valid_i, req_is_ptw_i, req_refill_i, req_way_hit_i, req_tlb_hit_i,
           req_line_i, req_offset_i, req_size_i, req_unsigned_i, req_stb_byp_vld_i,
           req_stb_byp_data_i, req_rob_tag_i, req_prd_i, req_lsu_tag_i,
           wb_ready_i, ptw_ready_i,
    output req_ready_o, wb_valid_o, wb_rob_tag_o, wb_prd_o, wb_lsu_tag_o, wb_data_o,
           wb_from_mlfb_o, ptw_valid_o, ptw_id_o, ptw_pte_o, ld_count_o
  );

  modport master (
    output req_valid_i, req_is_ptw_i, req_refill_i, req_way_hit_i, req_tlb_hit_i,
           req_line_i, req_offset_i, req_size_i, req_unsigned_i, req_stb_byp_vld_i,
           req_stb_byp_data_i, req_rob_tag_i, req_prd_i, req_lsu_tag_i,
           wb_ready_i, ptw_ready_i,
    input  req_ready_o, wb_valid_o, wb_rob_tag_o, wb_prd_o, wb_lsu_tag_o, wb_data_o,
           wb_from_mlfb_o, ptw_valid_o, ptw_id_o, ptw_pte_o, ld_count_o
  );

endinterface

// File: rtl/rvh_l1d_ld_data_fmt.sv
// Combinational load data select (bypass > refill > hit) and size/sign format.
// raw is the unformatted selection, used as-is for page-table walks.
module rvh_l1d_ld_data_fmt
  import rvh_l1d_pkg::*;
#(
  parameter int WAY_NUM   = 4,
  parameter int LINE_BITS = 512,
  parameter int XLEN      = 64,
  localparam int OFF_W    = $clog2(LINE_BITS/8)
) (
  input  logic                 refill,
  input  logic [WAY_NUM-1:0]   way_hit,
  input  logic [LINE_BITS-1:0] line,
  input  logic [OFF_W-1:0]     offset,
  input  logic [1:0]           size,
  input  logic                 is_unsigned,
  input  logic                 byp_vld,
  input  logic [XLEN-1:0]      byp_data,
  output logic [XLEN-1:0]      raw,
  output logic [XLEN-1:0]      data
);
  localparam int SEG       = LINE_BITS / WAY_NUM;
  localparam int SEG_BYTES = SEG / 8;

  logic [XLEN-1:0]      hit_data;
  logic [LINE_BITS-1:0] line_sh;
  int                   word_sh;

  always_comb begin
    logic [SEG-1:0] seg_sh;
    seg_sh   = '0;
    hit_data = '0;
    word_sh  = ((int'(offset) % SEG_BYTES) / 8) * XLEN;
    // multi-hot vectors simply OR the selected words together
    for (int w = 0; w < WAY_NUM; w++) begin
      if (way_hit[w]) begin
        seg_sh   = line[w*SEG +: SEG] >> word_sh;
        hit_data = hit_data | (seg_sh[XLEN-1:0] >> {offset[2:0], 3'b000});
      end
    end
  end

  assign line_sh = line >> {offset, 3'b000};

  always_comb begin
    raw = hit_data;
    if (byp_vld) raw = byp_data;
    else if (refill) raw = line_sh[XLEN-1:0];
  end

  always_comb begin
    case (size)
      SIZE_B:  data = {{(XLEN-8){raw[7] & ~is_unsigned}}, raw[7:0]};
      SIZE_H:  data = {{(XLEN-16){raw[15] & ~is_unsigned}}, raw[15:0]};
      SIZE_W:  data = {{(XLEN-32){raw[31] & ~is_unsigned}}, raw[31:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/rvh_l1d_ld_resp_queue.sv
// Buffered L1D load/PTW response stage: DEPTH-entry load FIFO plus one PTW slot.
// Request ready depends only on registered occupancy, so nothing passes through combinationally.
module rvh_l1d_ld_resp_queue
  import rvh_l1d_pkg::*;
#(
  parameter int WAY_NUM    = 4,
  parameter int LINE_BITS  = 512,
  parameter int XLEN       = 64,
  parameter int DEPTH      = 4,
  parameter int ROB_TAG_W  = 4,
  parameter int PREG_TAG_W = 4,
  parameter int LSU_TAG_W  = 12,
  parameter int PTW_ID_W   = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  rvh_l1d_ld_resp_queue_if.slave io
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ROB_TAG_W-1:0]  rob_tag;
    logic [PREG_TAG_W-1:0] prd;
    logic [LSU_TAG_W-1:0]  lsu_tag;
    logic [XLEN-1:0]       data;
    logic                  from_mlfb;
  } ld_q_entry_t;

  typedef struct packed {
    logic [PTW_ID_W-1:0] id;
    logic [XLEN-1:0]     pte;
  } ptw_q_entry_t;

  ld_q_entry_t      mem [DEPTH];
  ld_q_entry_t      rd_entry;
  ptw_q_entry_t     ptw_entry;
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             ptw_vld;
  logic [XLEN-1:0]  raw_data, fmt_data;
  logic             req_ready, accept, push, pop, ptw_push, ptw_pop, wb_vld;

  rvh_l1d_ld_data_fmt #(
    .WAY_NUM   (WAY_NUM),
    .LINE_BITS (LINE_BITS),
    .XLEN      (XLEN)
  ) u_fmt (
    .refill      (io.req_refill_i),
    .way_hit     (io.req_way_hit_i),
    .line        (io.req_line_i),
    .offset      (io.req_offset_i),
    .size        (io.req_size_i),
    .is_unsigned (io.req_unsigned_i),
    .byp_vld     (io.req_stb_byp_vld_i),
    .byp_data    (io.req_stb_byp_data_i),
    .raw         (raw_data),
    .data        (fmt_data)
  );

  assign req_ready = (count < CNT_W'(DEPTH)) & ~ptw_vld;
  assign accept    = io.req_valid_i & req_ready;
  // loads with no usable data source are consumed and left for upstream replay
  assign push      = accept & ~io.req_is_ptw_i &
                     (io.req_tlb_hit_i | io.req_refill_i | io.req_stb_byp_vld_i);
  assign ptw_push  = accept & io.req_is_ptw_i;
  assign wb_vld    = (count != '0);
  assign pop       = wb_vld & io.wb_ready_i;
  assign ptw_pop   = ptw_vld & io.ptw_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ptw_vld <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ptw_push)     ptw_vld <= 1'b1;
      else if (ptw_pop) ptw_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= '{rob_tag:   io.req_rob_tag_i,
                     prd:       io.req_prd_i,
                     lsu_tag:   io.req_lsu_tag_i,
                     data:      fmt_data,
                     from_mlfb: io.req_refill_i};
    end
    if (ptw_push) begin
      ptw_entry <= '{id: io.req_rob_tag_i[PTW_ID_W-1:0], pte: raw_data};
    end
  end

  assign rd_entry = mem[rptr];

  assign io.req_ready_o    = req_ready;
  assign io.wb_valid_o     = wb_vld;
  assign io.wb_rob_tag_o   = wb_vld ? rd_entry.rob_tag   : '0;
  assign io.wb_prd_o       = wb_vld ? rd_entry.prd       : '0;
  assign io.wb_lsu_tag_o   = wb_vld ? rd_entry.lsu_tag   : '0;
  assign io.wb_data_o      = wb_vld ? rd_entry.data      : '0;
  assign io.wb_from_mlfb_o = wb_vld & rd_entry.from_mlfb;
  assign io.ptw_valid_o    = ptw_vld;
  assign io.ptw_id_o       = ptw_vld ? ptw_entry.id  : '0;
  assign io.ptw_pte_o      = ptw_vld ? ptw_entry.pte : '0;
  assign io.ld_count_o     = count;

endmodule
